// File: rtl/cdb_broadcast_if.sv
// Bus bundle between the functional units, the reservation station and
// the CDB broadcaster.
//   branch_recover_i : flush all pending completions
//   complete_valid_i : per-FU completion strobe
//   complete_tag_i   : per-FU destination tag, slice i = [i*TAG_W +: TAG_W]
//   fu_ready_o       : per-FU ready (completion FIFO not full)
//   cdb_tag_o        : broadcast tags, lane-sliced
//   cdb_en_o         : per-lane broadcast valid
//   overflow_o       : sticky completion-FIFO overflow flag
// The master modport is the producer side (FUs / control); the slave
// modport is the broadcaster.
interface cdb_broadcast_if #(
    parameter int FU_NUM    = 5,
    parameter int TAG_W     = 6,
    parameter int CDB_WIDTH = 2
);
    logic                          branch_recover_i;
    logic [FU_NUM-1:0]             complete_valid_i;
    logic [FU_NUM*TAG_W-1:0]       complete_tag_i;
    logic [FU_NUM-1:0]             fu_ready_o;
    logic [CDB_WIDTH*TAG_W-1:0]    cdb_tag_o;
    logic [CDB_WIDTH-1:0]          cdb_en_o;
    logic                          overflow_o;

    modport master (
        output branch_recover_i, complete_valid_i, complete_tag_i,
        input  fu_ready_o, cdb_tag_o, cdb_en_o, overflow_o
    );

    modport slave (
        input  branch_recover_i, complete_valid_i, complete_tag_i,
        output fu_ready_o, cdb_tag_o, cdb_en_o, overflow_o
    );
endinterface

// File: rtl/cdb_broadcast.sv
// Completion-side broadcaster. Each FU owns a small completion FIFO; a
// round-robin arbiter picks up to CDB_WIDTH non-empty FIFO heads per cycle
// and registers them onto the common data bus.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : cdb_broadcast_if slave (completions in, ready/CDB/overflow out)
// All outputs are registered. fu_ready_o is the registered "not full" view
// of each FIFO, so it has no combinational path from the inputs.
module cdb_broadcast #(
    parameter int FU_NUM    = 5,
    parameter int PREG_NUM  = 64,
    parameter int CDB_WIDTH = 2,
    parameter int QDEPTH    = 2
) (
    input logic           clk,
    input logic           reset,
    cdb_broadcast_if.slave bus
);
    localparam int TAG_W  = $clog2(PREG_NUM);
    localparam int CNT_W  = $clog2(QDEPTH) + 1;
    localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int RR_W   = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
    localparam int LANE_W = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;

    // FIFO storage and bookkeeping
    logic [TAG_W-1:0]           mem_r   [FU_NUM][QDEPTH];
    logic [PTR_W-1:0]           head_r  [FU_NUM];
    logic [PTR_W-1:0]           tail_r  [FU_NUM];
    logic [CNT_W-1:0]           count_r [FU_NUM];
    logic [CNT_W-1:0]           count_nxt_s [FU_NUM];
    logic [RR_W-1:0]            rr_ptr_r;
    logic [FU_NUM-1:0]          fu_ready_r;
    logic                       overflow_r;
    logic [CDB_WIDTH*TAG_W-1:0] cdb_tag_r;
    logic [CDB_WIDTH-1:0]       cdb_en_r;

    // Arbitration / push decode
    logic [FU_NUM-1:0]          push_s;
    logic                       overflow_hit_s;
    logic [FU_NUM-1:0]          grant_s;
    logic [TAG_W-1:0]           lane_tag_s [CDB_WIDTH];
    logic [CDB_WIDTH-1:0]       lane_en_s;
    logic [LANE_W-1:0]          lane_s;
    logic                       lanes_full_s;
    logic                       any_grant_s;
    logic [RR_W-1:0]            last_s;
    logic [RR_W:0]              sum_s;
    logic [RR_W-1:0]            idx_s;

    // Wrap-around increment; equals natural wrap for power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(QDEPTH - 1)) begin
            return PTR_W'(0);
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign bus.fu_ready_o = fu_ready_r;
    assign bus.cdb_tag_o  = cdb_tag_r;
    assign bus.cdb_en_o   = cdb_en_r;
    assign bus.overflow_o = overflow_r;

    // Push qualification: zero tags are acknowledged but never stored.
    always_comb begin
        push_s         = {FU_NUM{1'b0}};
        overflow_hit_s = 1'b0;
        for (int i = 0; i < FU_NUM; i++) begin
            push_s[i] = bus.complete_valid_i[i] && fu_ready_r[i] &&
                        (bus.complete_tag_i[i*TAG_W +: TAG_W] != TAG_W'(0));
            if (bus.complete_valid_i[i] && !fu_ready_r[i]) begin
                overflow_hit_s = 1'b1;
            end else begin
                overflow_hit_s = overflow_hit_s;
            end
        end
    end

    // Round-robin scan from rr_ptr over registered FIFO state; first grant
    // in scan order lands on lane 0.
    always_comb begin
        grant_s      = {FU_NUM{1'b0}};
        lane_en_s    = {CDB_WIDTH{1'b0}};
        lane_s       = LANE_W'(0);
        lanes_full_s = 1'b0;
        any_grant_s  = 1'b0;
        last_s       = rr_ptr_r;
        sum_s        = (RR_W+1)'(0);
        idx_s        = RR_W'(0);
        for (int l = 0; l < CDB_WIDTH; l++) begin
            lane_tag_s[l] = TAG_W'(0);
        end
        for (int k = 0; k < FU_NUM; k++) begin
            sum_s = {1'b0, rr_ptr_r} + (RR_W+1)'(k);
            idx_s = (sum_s >= (RR_W+1)'(FU_NUM)) ? RR_W'(sum_s - (RR_W+1)'(FU_NUM))
                                                 : RR_W'(sum_s);
            if ((count_r[idx_s] != CNT_W'(0)) && !lanes_full_s) begin
                grant_s[idx_s]     = 1'b1;
                lane_en_s[lane_s]  = 1'b1;
                lane_tag_s[lane_s] = mem_r[idx_s][head_r[idx_s]];
                last_s             = idx_s;
                any_grant_s        = 1'b1;
                if (lane_s == LANE_W'(CDB_WIDTH - 1)) begin
                    lanes_full_s = 1'b1;
                end else begin
                    lane_s = lane_s + LANE_W'(1);
                end
            end else begin
                lane_s = lane_s;
            end
        end
    end

    // Next occupancy per FIFO: simultaneous push and pop leave it unchanged.
    always_comb begin
        for (int i = 0; i < FU_NUM; i++) begin
            case ({push_s[i], grant_s[i]})
                2'b10:   count_nxt_s[i] = count_r[i] + CNT_W'(1);
                2'b01:   count_nxt_s[i] = count_r[i] - CNT_W'(1);
                default: count_nxt_s[i] = count_r[i];
            endcase
        end
    end

    // State update: reset, then branch recovery, then normal push/pop/broadcast.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FU_NUM; i++) begin
                head_r[i]  <= PTR_W'(0);
                tail_r[i]  <= PTR_W'(0);
                count_r[i] <= CNT_W'(0);
                for (int d = 0; d < QDEPTH; d++) begin
                    mem_r[i][d] <= TAG_W'(0);
                end
            end
            rr_ptr_r   <= RR_W'(0);
            fu_ready_r <= {FU_NUM{1'b1}};
            overflow_r <= 1'b0;
            cdb_tag_r  <= {(CDB_WIDTH*TAG_W){1'b0}};
            cdb_en_r   <= {CDB_WIDTH{1'b0}};
        end else if (bus.branch_recover_i) begin
            // Flush drops queued and in-flight completions; overflow is kept.
            for (int i = 0; i < FU_NUM; i++) begin
                head_r[i]  <= PTR_W'(0);
                tail_r[i]  <= PTR_W'(0);
                count_r[i] <= CNT_W'(0);
            end
            rr_ptr_r   <= RR_W'(0);
            fu_ready_r <= {FU_NUM{1'b1}};
            cdb_tag_r  <= {(CDB_WIDTH*TAG_W){1'b0}};
            cdb_en_r   <= {CDB_WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < FU_NUM; i++) begin
                if (push_s[i]) begin
                    mem_r[i][tail_r[i]] <= bus.complete_tag_i[i*TAG_W +: TAG_W];
                    tail_r[i]           <= ptr_inc(tail_r[i]);
                end
                if (grant_s[i]) begin
                    head_r[i] <= ptr_inc(head_r[i]);
                end
                count_r[i]    <= count_nxt_s[i];
                fu_ready_r[i] <= (count_nxt_s[i] != CNT_W'(QDEPTH));
            end
            for (int l = 0; l < CDB_WIDTH; l++) begin
                cdb_tag_r[l*TAG_W +: TAG_W] <= lane_tag_s[l];
            end
            cdb_en_r   <= lane_en_s;
            overflow_r <= overflow_r | overflow_hit_s;
            if (any_grant_s) begin
                rr_ptr_r <= (last_s == RR_W'(FU_NUM - 1)) ? RR_W'(0) : last_s + RR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_cdb_broadcast.sv
module tb_cdb_broadcast;
    localparam int FU_NUM    = 5;
    localparam int PREG_NUM  = 64;
    localparam int TAG_W     = 6;
    localparam int CDB_WIDTH = 2;
    localparam int QDEPTH    = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cdb_broadcast_if #(.FU_NUM(FU_NUM), .TAG_W(TAG_W), .CDB_WIDTH(CDB_WIDTH)) bus();

    cdb_broadcast #(.FU_NUM(FU_NUM), .PREG_NUM(PREG_NUM), .CDB_WIDTH(CDB_WIDTH),
                    .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: one queue per FU plus scan pointer
    int          mq [FU_NUM][$];
    int          m_rr;
    logic [1:0]  m_en;
    int          m_tag [2];
    logic        m_ovf;
    logic [4:0]  m_ready;
    bit          m_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int sz [FU_NUM];
        int g;
        int idx;
        int last;
        if (reset) begin
            for (int i = 0; i < FU_NUM; i++) mq[i].delete();
            m_rr = 0; m_en = 2'b00; m_tag[0] = 0; m_tag[1] = 0; m_ovf = 1'b0;
        end else if (bus.branch_recover_i) begin
            for (int i = 0; i < FU_NUM; i++) mq[i].delete();
            m_rr = 0; m_en = 2'b00; m_tag[0] = 0; m_tag[1] = 0;
        end else begin
            for (int i = 0; i < FU_NUM; i++) sz[i] = mq[i].size();
            m_en = 2'b00; m_tag[0] = 0; m_tag[1] = 0;
            g = 0; last = -1;
            for (int k = 0; k < FU_NUM; k++) begin
                idx = (m_rr + k) % FU_NUM;
                if (sz[idx] > 0 && g < CDB_WIDTH) begin
                    m_tag[g] = mq[idx].pop_front();
                    m_en[g]  = 1'b1;
                    g++;
                    last = idx;
                end
            end
            if (last >= 0) m_rr = (last + 1) % FU_NUM;
            for (int i = 0; i < FU_NUM; i++) begin
                if (bus.complete_valid_i[i]) begin
                    if (sz[i] == QDEPTH) m_ovf = 1'b1;
                    else if (bus.complete_tag_i[i*TAG_W +: TAG_W] != 0)
                        mq[i].push_back(int'(bus.complete_tag_i[i*TAG_W +: TAG_W]));
                end
            end
        end
        for (int i = 0; i < FU_NUM; i++) m_ready[i] = (mq[i].size() != QDEPTH);
        m_ok = 1'b1;
    endtask

    task automatic compare_model();
        if (m_ok) begin
            chk("model_ready", 32'(bus.fu_ready_o), 32'(m_ready));
            chk("model_en",    32'(bus.cdb_en_o), 32'(m_en));
            chk("model_tag0",  32'(bus.cdb_tag_o[TAG_W-1:0]), 32'(m_tag[0]));
            chk("model_tag1",  32'(bus.cdb_tag_o[2*TAG_W-1:TAG_W]), 32'(m_tag[1]));
            chk("model_ovf",   32'(bus.overflow_o), 32'(m_ovf));
        end
    endtask

    // One clock: model follows the edge, outputs checked 1ns later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic clear_in();
        bus.branch_recover_i = 1'b0;
        bus.complete_valid_i = '0;
        bus.complete_tag_i   = '0;
    endtask

    task automatic push(input int fu, input int tag);
        bus.complete_valid_i[fu]               = 1'b1;
        bus.complete_tag_i[fu*TAG_W +: TAG_W]  = TAG_W'(tag);
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int cnt  [FU_NUM];
    int lastc[FU_NUM];
    int f;

    initial begin
        clear_in();
        reset = 1'b1;
        tick();
        tick();
        chk("reset_ready", 32'(bus.fu_ready_o), 32'h1f);
        chk("reset_en",    32'(bus.cdb_en_o), 32'h0);
        chk("reset_tag",   32'(bus.cdb_tag_o), 32'h0);
        chk("reset_ovf",   32'(bus.overflow_o), 32'h0);
        reset = 1'b0;

        // Single completion
        push(2, 7); tick(); clear_in();
        chk("single_wait_en", 32'(bus.cdb_en_o), 32'h0);
        tick();
        chk("single_en",  32'(bus.cdb_en_o), 32'h1);
        chk("single_tag", 32'(bus.cdb_tag_o[TAG_W-1:0]), 32'd7);
        tick();
        chk("single_idle", 32'(bus.cdb_en_o), 32'h0);

        // Three simultaneous completions from rr_ptr=0
        do_reset();
        push(0, 5); push(1, 9); push(3, 12); tick(); clear_in();
        tick();
        chk("three_en1",   32'(bus.cdb_en_o), 32'h3);
        chk("three_l0",    32'(bus.cdb_tag_o[TAG_W-1:0]), 32'd5);
        chk("three_l1",    32'(bus.cdb_tag_o[2*TAG_W-1:TAG_W]), 32'd9);
        tick();
        chk("three_en2",   32'(bus.cdb_en_o), 32'h1);
        chk("three_l0b",   32'(bus.cdb_tag_o[TAG_W-1:0]), 32'd12);
        // rr_ptr now 4: FU4 must win lane 0 over FU0
        push(0, 30); push(4, 31); tick(); clear_in(); tick();
        chk("rr4_l0", 32'(bus.cdb_tag_o[TAG_W-1:0]), 32'd31);
        chk("rr4_l1", 32'(bus.cdb_tag_o[2*TAG_W-1:TAG_W]), 32'd30);

        // Back-pressure on FU1
        do_reset();
        push(2, 21); push(3, 22); push(4, 23); push(0, 24); tick(); clear_in();
        push(1, 3); push(0, 25); push(2, 26); tick(); clear_in();
        chk("bp_e1_l0", 32'(bus.cdb_tag_o[TAG_W-1:0]), 32'd24);
        chk("bp_e1_l1", 32'(bus.cdb_tag_o[2*TAG_W-1:TAG_W]), 32'd21);
        push(1, 4); tick(); clear_in();
        chk("bp_e2_l0",  32'(bus.cdb_tag_o[TAG_W-1:0]), 32'd22);
        chk("bp_ready",  32'(bus.fu_ready_o), 32'b11101);
        push(1, 6); tick(); clear_in();
        chk("bp_ovf",    32'(bus.overflow_o), 32'h1);
        chk("bp_e3_l0",  32'(bus.cdb_tag_o[TAG_W-1:0]), 32'd25);
        chk("bp_e3_l1",  32'(bus.cdb_tag_o[2*TAG_W-1:TAG_W]), 32'd3);
        tick();
        chk("bp_e4_l0",  32'(bus.cdb_tag_o[TAG_W-1:0]), 32'd26);
        chk("bp_e4_l1",  32'(bus.cdb_tag_o[2*TAG_W-1:TAG_W]), 32'd4);
        tick();
        chk("bp_drained", 32'(bus.cdb_en_o), 32'h0);

        // Zero tag is never stored
        do_reset();
        push(4, 0); tick(); clear_in();
        tick();
        chk("zero_en1",    32'(bus.cdb_en_o), 32'h0);
        tick();
        chk("zero_en2",    32'(bus.cdb_en_o), 32'h0);
        chk("zero_ready",  32'(bus.fu_ready_o), 32'h1f);

        // Flush with a concurrent push
        do_reset();
        push(0, 10); push(1, 11); tick(); clear_in();
        bus.branch_recover_i = 1'b1; push(3, 13); tick(); clear_in();
        chk("flush_en",    32'(bus.cdb_en_o), 32'h0);
        chk("flush_ready", 32'(bus.fu_ready_o), 32'h1f);
        chk("flush_tag",   32'(bus.cdb_tag_o), 32'h0);
        tick();
        chk("flush_en2",   32'(bus.cdb_en_o), 32'h0);
        push(0, 41); push(4, 40); tick(); clear_in(); tick();
        chk("flush_rr_l0", 32'(bus.cdb_tag_o[TAG_W-1:0]), 32'd41);
        chk("flush_rr_l1", 32'(bus.cdb_tag_o[2*TAG_W-1:TAG_W]), 32'd40);

        // Fairness: everyone completes every cycle for 10 cycles
        do_reset();
        for (int i = 0; i < FU_NUM; i++) begin cnt[i] = 0; lastc[i] = -1; end
        for (int c = 0; c <= 10; c++) begin
            clear_in();
            if (c < 10) for (int i = 0; i < FU_NUM; i++) push(i, i*8 + (c % 7) + 1);
            tick();
            if (c >= 1) begin
                for (int l = 0; l < CDB_WIDTH; l++) begin
                    if (bus.cdb_en_o[l]) begin
                        f = int'(bus.cdb_tag_o[l*TAG_W +: TAG_W]) / 8;
                        if (f < FU_NUM) begin
                            cnt[f]++;
                            if (lastc[f] >= 0) chk("fair_gap_le3", 32'(c - lastc[f] <= 3), 32'd1);
                            lastc[f] = c;
                        end
                    end
                end
            end
        end
        clear_in();
        for (int i = 0; i < FU_NUM; i++) chk("fair_count", 32'(cnt[i]), 32'd4);

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 3000; c++) begin
            clear_in();
            for (int i = 0; i < FU_NUM; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    push(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)));
                end
            end
            bus.branch_recover_i = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        clear_in();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_broadcast.md
Name: cdb_broadcast

Overview:
- Completion-side counterpart of the reservation station. It collects finished-instruction destination tags from the functional units and broadcasts them on the 2-wide CDB (tag plus enable per lane).
- It drives the per-FU ready back-pressure that the RS uses at issue.
- Each FU has a small completion FIFO. A round-robin arbiter picks up to CDB_WIDTH FIFO heads per cycle.

Parameters:
- FU_NUM, 5, number of functional units (same bit order as the RS FU select vector).
- PREG_NUM, 64, physical register count; TAG_W = $clog2(PREG_NUM).
- CDB_WIDTH, 2, broadcast lanes per cycle.
- QDEPTH, 2, entries per FU completion FIFO (power of 2, ≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- branch_recover_i  in  1  flush all pending completions.
- complete_valid_i  in  FU_NUM  FU i presents a completed tag this cycle.
- complete_tag_i  in  FU_NUM*TAG_W  destination tag per FU; slice i = bits [i*TAG_W +: TAG_W].
- fu_ready_o  out  FU_NUM  FU i may be issued to / may complete (FIFO i not full).
- cdb_tag_o  out  CDB_WIDTH*TAG_W  broadcast tags, lane-sliced.
- cdb_en_o  out  CDB_WIDTH  lane valid.
- overflow_o  out  1  sticky: a push arrived while the FIFO was full.

Behaviour:
- Reset: all FIFOs empty, rr_ptr=0, cdb_tag_o=0, cdb_en_o=0, overflow_o=0. fu_ready_o is all ones in the cycle after reset.
- fu_ready_o[i] = (count[i] != QDEPTH). It is decoded from registered counts only and has no combinational path from inputs.
- Push:
  - If complete_valid_i[i] && fu_ready_o[i], write the tag to FIFO i.
  - Tag 0 (zero register) is accepted but not stored.
  - If complete_valid_i[i] && !fu_ready_o[i], the push is dropped and overflow_o is set (cleared only by reset).
- Arbitration (combinational on registered FIFO state):
  - Scan FU indices starting at rr_ptr, wrapping modulo FU_NUM.
  - Grant the first CDB_WIDTH non-empty FIFOs, at most one pop per FIFO per cycle.
  - The first grant in scan order goes to lane 0, the second to lane 1.
- Output: granted heads are registered into cdb_tag_o/cdb_en_o and popped at the same edge. Ungranted lanes: en=0, tag=0.
- Latency: a tag pushed at edge t (FIFO empty, uncontested) appears on the CDB in the cycle following edge t+1. The RS sees it one cycle after that through its own register.
- rr_ptr update: if any grant occurred, rr_ptr <= (last granted index + 1) mod FU_NUM; otherwise it is unchanged. No FU with a nonempty FIFO starves longer than ceil(FU_NUM/CDB_WIDTH) cycles.
- Push and pop on the same FIFO in the same cycle:
  - Both occur and count is unchanged.
  - A FIFO that was empty cannot be popped that cycle, because arbitration uses registered state; there is no bypass.
  - A full FIFO keeps fu_ready_o low that cycle even though it is popping.
- Pointer arithmetic: per-FIFO head/tail are $clog2(QDEPTH) bits with natural wrap. count is $clog2(QDEPTH)+1 bits.
- branch_recover_i (priority over push/pop/arbitration):
  - At the edge, all FIFOs are emptied, cdb_en_o is cleared to 0, and rr_ptr is reset to 0.
  - Pushes in that cycle are discarded.
  - overflow_o is unchanged.
- Reset mid-operation: identical to the reset state regardless of FIFO contents or pending pushes.
- cdb_tag_o is never nonzero while the corresponding cdb_en_o lane is 0.

Test Plan:
- Single completion: reset; FU2 pushes tag 7 → next cycle count[2]=1; following cycle cdb_en_o=2'b01, lane0 tag=7; then idle with en=0.
- Three simultaneous completions with rr_ptr=0:
  - FU0=5, FU1=9, FU3=12 → first broadcast: lane0=5, lane1=9, rr_ptr=2.
  - Next broadcast: lane0=12, en=2'b01, rr_ptr=4.
- Back-pressure: FU1 pushes 3 then 4 with no drain cycle (CDB blocked by FU0/FU2/FU3/FU4 traffic) → fu_ready_o[1]=0 while count=2; a third push of 6 is dropped, overflow_o=1; tags 3 and 4 are broadcast in order, 6 never appears.
- Zero tag: FU4 pushes tag 0 → count[4] stays 0, no CDB enable.
- Flush: FIFOs FU0/FU1 hold tags 10 and 11, FU3 pushes in the same cycle as branch_recover_i=1 → next cycle all counts 0, cdb_en_o=0, fu_ready_o=5'b11111, rr_ptr=0.
- Fairness: all five FUs push every cycle for 10 cycles → each FU gets exactly 4 grants in 10 broadcast cycles; no FU waits more than 3 cycles with a nonempty FIFO.
